// File: rtl/retospect_neuron_pkg.sv
`default_nettype none
// ============================================================================
// Module      : retospect_neuron_pkg
// Description : Shared types and widths for the retospect LIF neuron core.
// Revision    : 1.0 - initial release
// ============================================================================
package retospect_neuron_pkg;

    localparam int W_WIDTH   = 3;  // signed synaptic weight
    localparam int UT_WIDTH  = 4;  // unsigned firing threshold
    localparam int N_INPUTS  = 4;  // spike input lines per neuron
    localparam int SUM_WIDTH = 5;  // signed weighted-sum width (-16..+12)

    typedef enum logic [1:0] {
        INTEGRATE = 2'd0,
        FIRE      = 2'd1,
        REFRACT   = 2'd2
    } state_t;

endpackage : retospect_neuron_pkg
`default_nettype wire

// File: rtl/retospect_neuron_if.sv
`default_nettype none
// ============================================================================
// Module      : retospect_neuron_if
// Description : Config, tick and spike signals between a CNB and its neuron
//               core. master = CNB/environment side, slave = neuron core.
// Revision    : 1.0 - initial release
// ============================================================================
interface retospect_neuron_if #(
    parameter int PW = 5
);
    import retospect_neuron_pkg::*;

    logic                 reset_nn;
    logic                 config_en;
    logic [N_INPUTS-1:0]  in_spike;
    logic [W_WIDTH-1:0]   w1;
    logic [W_WIDTH-1:0]   w2;
    logic [W_WIDTH-1:0]   w3;
    logic [W_WIDTH-1:0]   w4;
    logic [UT_WIDTH-1:0]  uT;
    logic [2:0]           decay_sel;
    logic [7:0]           clockbus;
    logic                 spike_out;
    logic [PW-1:0]        potential;
    logic                 refractory;
    logic [7:0]           spike_count;

    modport master (
        output reset_nn, config_en, in_spike, w1, w2, w3, w4, uT,
               decay_sel, clockbus,
        input  spike_out, potential, refractory, spike_count
    );

    modport slave (
        input  reset_nn, config_en, in_spike, w1, w2, w3, w4, uT,
               decay_sel, clockbus,
        output spike_out, potential, refractory, spike_count
    );

endinterface : retospect_neuron_if
`default_nettype wire

// File: rtl/retospect_weight_adder.sv
`default_nettype none
// ============================================================================
// Module      : retospect_weight_adder
// Description : Combinational signed sum of the weights whose input spike
//               line is set (bit i gates weight w(i+1)).
// Revision    : 1.0 - initial release
// ============================================================================
module retospect_weight_adder
    import retospect_neuron_pkg::*;
(
    input  wire logic [N_INPUTS-1:0]  in_spike,
    input  wire logic [W_WIDTH-1:0]   w1,
    input  wire logic [W_WIDTH-1:0]   w2,
    input  wire logic [W_WIDTH-1:0]   w3,
    input  wire logic [W_WIDTH-1:0]   w4,
    output      logic [SUM_WIDTH-1:0] sum
);

    logic [W_WIDTH-1:0] w_weight [N_INPUTS];

    assign w_weight[0] = w1;
    assign w_weight[1] = w2;
    assign w_weight[2] = w3;
    assign w_weight[3] = w4;

    // Sign-extend each gated weight and accumulate; 5 bits cannot overflow
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (in_spike[i]) begin
                sum = sum + {{(SUM_WIDTH-W_WIDTH){w_weight[i][W_WIDTH-1]}},
                             w_weight[i]};
            end
        end
    end

endmodule : retospect_weight_adder
`default_nettype wire

// File: rtl/retospect_neuron_core.sv
`default_nettype none
// ============================================================================
// Module      : retospect_neuron_core
// Description : Leaky integrate-and-fire neuron. Integrates four weighted
//               spike inputs into a clamped membrane potential, fires a
//               one-cycle registered spike at threshold uT, then sits out a
//               refractory period.
//               Optional spike counter: define RETOSPECT_SPIKE_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module retospect_neuron_core
    import retospect_neuron_pkg::*;
#(
    parameter int PW             = 5,
    parameter int REFRACT_CYCLES = 2,
    parameter int RCW            = 3
) (
    input  wire logic          clk,
    input  wire logic          reset,
    retospect_neuron_if.slave  bus
);

    localparam int            c_ext_w       = PW + 2;
    localparam logic [PW-1:0] c_pot_max     = '1;
    localparam logic [RCW-1:0] c_refract_load =
        (REFRACT_CYCLES == 0) ? '0 : RCW'(REFRACT_CYCLES - 1);

    state_t          r_state;
    logic [PW-1:0]   r_pot;
    logic [RCW-1:0]  r_cnt;
    logic            r_spike;

    logic [SUM_WIDTH-1:0] w_sum;
    logic                 w_leak;
    logic [c_ext_w-1:0]   w_next_raw;
    logic [PW-1:0]        w_next;
    logic                 w_fire;
    logic                 w_clear;

    retospect_weight_adder u_adder (
        .in_spike (bus.in_spike),
        .w1       (bus.w1),
        .w2       (bus.w2),
        .w3       (bus.w3),
        .w4       (bus.w4),
        .sum      (w_sum)
    );

    assign w_leak  = bus.clockbus[bus.decay_sel];
    assign w_clear = reset | bus.config_en | bus.reset_nn;

    // Next potential at PW+2 bits: MSB set means negative, bit PW means overflow
    always_comb begin
        w_next_raw = {2'b00, r_pot}
                   + {{(c_ext_w-SUM_WIDTH){w_sum[SUM_WIDTH-1]}}, w_sum}
                   - {{(c_ext_w-1){1'b0}}, w_leak};
        if (w_next_raw[c_ext_w-1]) begin
            w_next = '0;
        end else if (w_next_raw[PW]) begin
            w_next = c_pot_max;
        end else begin
            w_next = w_next_raw[PW-1:0];
        end
        w_fire = (w_next >= PW'(bus.uT));
    end

    // Neuron FSM with registered potential, spike and refractory counter
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state <= INTEGRATE;
            r_pot   <= '0;
            r_spike <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                INTEGRATE: begin
                    if (w_fire) begin
                        r_state <= FIRE;
                        r_pot   <= '0;
                        r_spike <= 1'b1;
                    end else begin
                        r_pot   <= w_next;
                        r_spike <= 1'b0;
                    end
                end
                FIRE: begin
                    r_spike <= 1'b0;
                    r_pot   <= '0;
                    if (REFRACT_CYCLES == 0) begin
                        r_state <= INTEGRATE;
                    end else begin
                        r_state <= REFRACT;
                        r_cnt   <= c_refract_load;
                    end
                end
                REFRACT: begin
                    r_spike <= 1'b0;
                    r_pot   <= '0;
                    if (r_cnt == '0) begin
                        r_state <= INTEGRATE;
                    end else begin
                        r_cnt   <= r_cnt - RCW'(1);
                    end
                end
                default: begin
                    r_state <= INTEGRATE;
                    r_pot   <= '0;
                    r_spike <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.spike_out  = r_spike;
    assign bus.potential  = r_pot;
    assign bus.refractory = (r_state == REFRACT);

`ifdef RETOSPECT_SPIKE_COUNT_EN
    logic [7:0] r_spike_count;

    // Saturating count of FIRE entries; config_en holds it, reset_nn clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_spike_count <= '0;
        end else if (bus.config_en) begin
            r_spike_count <= r_spike_count;
        end else if (bus.reset_nn) begin
            r_spike_count <= '0;
        end else if (r_state == INTEGRATE && w_fire && r_spike_count != 8'hFF) begin
            r_spike_count <= r_spike_count + 8'd1;
        end
    end

    assign bus.spike_count = r_spike_count;
`else
    assign bus.spike_count = 8'd0;
`endif

endmodule : retospect_neuron_core
`default_nettype wire

// File: tb/tb_retospect_neuron_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_retospect_neuron_core
// Description : Self-checking bench: table of per-cycle vectors followed by
//               hand-written reset/always-fire/counter sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_retospect_neuron_core;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    retospect_neuron_if #(.PW(5)) nif ();

    retospect_neuron_core #(
        .PW             (5),
        .REFRACT_CYCLES (2),
        .RCW            (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (nif)
    );

    typedef struct {
        logic       rnn;
        logic       cen;
        logic [3:0] ins;
        logic [2:0] w1, w2, w3, w4;
        logic [3:0] ut;
        logic [2:0] ds;
        logic       e_spk;
        logic [4:0] e_pot;
        logic       e_ref;
    } vec_t;

    localparam int NV = 36;
    vec_t vecs [NV];

    int errors = 0;
    int checks = 0;

    function automatic vec_t mk(logic rnn, logic cen, logic [3:0] ins,
                                logic [2:0] w1, logic [2:0] w2,
                                logic [2:0] w3, logic [2:0] w4,
                                logic [3:0] ut, logic [2:0] ds,
                                logic e_spk, logic [4:0] e_pot, logic e_ref);
        vec_t v;
        v.rnn = rnn; v.cen = cen; v.ins = ins;
        v.w1 = w1; v.w2 = w2; v.w3 = w3; v.w4 = w4;
        v.ut = ut; v.ds = ds;
        v.e_spk = e_spk; v.e_pot = e_pot; v.e_ref = e_ref;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input int idx,
                            input logic spk, input logic [4:0] pot,
                            input logic rf);
        chk({name, ".spike"}, idx, 32'(nif.spike_out), 32'(spk));
        chk({name, ".pot"},   idx, 32'(nif.potential), 32'(pot));
        chk({name, ".ref"},   idx, 32'(nif.refractory), 32'(rf));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 3'b111=-1, 3'b110=-2, 3'b100=-4; clockbus bit1=1, all others 0
        vecs[0]  = mk(0,0,4'b0001, 3,0,0,0,  5,0, 0, 3,0); // accumulate
        vecs[1]  = mk(0,0,4'b0001, 3,0,0,0,  5,0, 1, 0,0); // 6>=5 fires
        vecs[2]  = mk(0,0,4'b0001, 3,0,0,0,  5,0, 0, 0,1);
        vecs[3]  = mk(0,0,4'b0001, 3,0,0,0,  5,0, 0, 0,1);
        vecs[4]  = mk(0,0,4'b0001, 3,0,0,0,  5,0, 0, 0,0);
        vecs[5]  = mk(0,0,4'b0001, 3,0,0,0,  5,0, 0, 3,0);
        vecs[6]  = mk(0,0,4'b0001, 3,0,0,0,  5,0, 1, 0,0);
        vecs[7]  = mk(1,0,4'b0001, 3,0,0,0,  5,0, 0, 0,0); // reset_nn in FIRE
        vecs[8]  = mk(0,0,4'b0001, 2,0,0,0, 15,0, 0, 2,0);
        vecs[9]  = mk(0,0,4'b0001, 2,0,0,0, 15,0, 0, 4,0);
        vecs[10] = mk(0,0,4'b0000, 2,0,0,0, 15,1, 0, 3,0); // leak
        vecs[11] = mk(0,0,4'b0000, 2,0,0,0, 15,1, 0, 2,0);
        vecs[12] = mk(0,0,4'b0000, 2,0,0,0, 15,1, 0, 1,0);
        vecs[13] = mk(0,0,4'b0000, 2,0,0,0, 15,1, 0, 0,0);
        vecs[14] = mk(0,0,4'b0000, 2,0,0,0, 15,1, 0, 0,0); // no underflow
        vecs[15] = mk(0,0,4'b0001, 2,0,0,0, 15,0, 0, 2,0);
        vecs[16] = mk(0,0,4'b0010, 2,4,0,0, 15,0, 0, 0,0); // inhibition clamp
        vecs[17] = mk(0,0,4'b1111, 3,3,3,3, 15,0, 0,12,0); // max sum
        vecs[18] = mk(0,0,4'b1111, 3,3,3,3, 15,0, 1, 0,0);
        vecs[19] = mk(0,0,4'b1111, 3,3,3,3, 15,0, 0, 0,1); // inputs ignored
        vecs[20] = mk(0,0,4'b1111, 3,3,3,3, 15,0, 0, 0,1);
        vecs[21] = mk(0,0,4'b0000, 3,3,3,3, 15,0, 0, 0,0);
        vecs[22] = mk(0,0,4'b0111, 3,7,2,4, 15,0, 0, 4,0); // 3-1+2
        vecs[23] = mk(0,0,4'b1101, 3,7,2,4, 15,0, 0, 5,0); // 3+2-4
        vecs[24] = mk(0,0,4'b0000, 3,7,2,4, 15,2, 0, 5,0); // tick bit low
        vecs[25] = mk(0,0,4'b0001, 3,0,0,0, 15,1, 0, 7,0); // 5-1+3
        vecs[26] = mk(0,0,4'b0001, 1,0,0,0,  8,0, 1, 0,0); // next==uT fires
        vecs[27] = mk(0,1,4'b0001, 1,0,0,0,  8,0, 0, 0,0); // config_en in FIRE
        vecs[28] = mk(0,0,4'b0000, 1,0,0,0, 15,0, 0, 0,0);
        vecs[29] = mk(0,0,4'b0000, 0,0,0,0,  0,0, 1, 0,0); // uT=0 fires
        vecs[30] = mk(0,0,4'b0000, 0,0,0,0,  0,0, 0, 0,1);
        vecs[31] = mk(0,1,4'b0001, 3,0,0,0,  0,0, 0, 0,0); // config_en in REFRACT
        vecs[32] = mk(0,0,4'b0000, 3,0,0,0, 15,0, 0, 0,0); // back in INTEGRATE
        vecs[33] = mk(0,0,4'b0001, 3,0,0,0, 15,1, 0, 2,0); // 0-1+3
        vecs[34] = mk(0,0,4'b0001, 1,0,0,0,  4,0, 0, 3,0); // next=uT-1 holds
        vecs[35] = mk(0,0,4'b0001, 1,0,0,0,  4,0, 1, 0,0);

        reset         = 1'b1;
        nif.reset_nn  = 1'b0;
        nif.config_en = 1'b0;
        nif.in_spike  = '0;
        nif.w1 = '0; nif.w2 = '0; nif.w3 = '0; nif.w4 = '0;
        nif.uT        = 4'd15;
        nif.decay_sel = 3'd0;
        nif.clockbus  = 8'b0000_0010;

        tick();
        tick();
        chk_outs("reset", 0, 1'b0, 5'd0, 1'b0);
        chk("reset.count", 0, 32'(nif.spike_count), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            nif.reset_nn  = vecs[i].rnn;
            nif.config_en = vecs[i].cen;
            nif.in_spike  = vecs[i].ins;
            nif.w1 = vecs[i].w1; nif.w2 = vecs[i].w2;
            nif.w3 = vecs[i].w3; nif.w4 = vecs[i].w4;
            nif.uT        = vecs[i].ut;
            nif.decay_sel = vecs[i].ds;
            tick();
            chk_outs("vec", i, vecs[i].e_spk, vecs[i].e_pot, vecs[i].e_ref);
        end
        nif.reset_nn  = 1'b0;
        nif.config_en = 1'b0;

`ifdef RETOSPECT_SPIKE_COUNT_EN
        // fires at 18, 26, 29, 35 counted after reset_nn at vec 7
        chk("table.count", 0, 32'(nif.spike_count), 32'd4);
`else
        chk("table.count", 0, 32'(nif.spike_count), 32'd0);
`endif

        // Always-fire neuron: spike one cycle in four from reset release
        nif.in_spike = '0;
        nif.uT       = 4'd0;
        reset        = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            chk_outs("always", k, (k % 4) == 1, 5'd0,
                     ((k % 4) == 2) || ((k % 4) == 3));
        end

        // Reset while spike_out is high (k=13 fired)
        reset = 1'b1;
        tick();
        chk_outs("rst_spike", 0, 1'b0, 5'd0, 1'b0);
        reset = 1'b0;
        tick();
        chk_outs("rst_spike", 1, 1'b1, 5'd0, 1'b0);
        tick();
        chk_outs("rst_spike", 2, 1'b0, 5'd0, 1'b1);

        // Reset in REFRACT
        reset = 1'b1;
        tick();
        chk_outs("rst_refr", 0, 1'b0, 5'd0, 1'b0);
        reset = 1'b0;

`ifdef RETOSPECT_SPIKE_COUNT_EN
        // Saturation: 300 firings at one per 4 cycles
        for (int k = 0; k < 1200; k++) begin
            tick();
        end
        chk("sat.count", 0, 32'(nif.spike_count), 32'd255);
        nif.config_en = 1'b1;
        tick();
        chk("sat.hold", 0, 32'(nif.spike_count), 32'd255);
        nif.config_en = 1'b0;
        nif.uT        = 4'd15;
        nif.reset_nn  = 1'b1;
        tick();
        chk("sat.clear", 0, 32'(nif.spike_count), 32'd0);
        nif.reset_nn = 1'b0;
`else
        for (int k = 0; k < 8; k++) begin
            tick();
        end
        chk("tied.count", 0, 32'(nif.spike_count), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_retospect_neuron_core
`default_nettype wire
